// File: rtl/elevator.sv
// Single-car controller for a five-floor shaft: latches floor requests and
// serves them in SCAN order with fixed per-floor travel and door dwell times.
module elevator #(
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] buttons,
    output logic [2:0] current_floor,
    output logic       door_open,
    output logic [4:0] pending
);

    localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN,
        DOOR
    } state_t;

    state_t        state;
    logic          dir_up;
    logic [MW-1:0] move_cnt;
    logic [DW-1:0] door_cnt;

    logic [4:0] req;
    logic [4:0] above_mask;
    logic [4:0] below_mask;
    logic [4:0] here_mask;
    logic [4:0] arrive_mask;
    logic [4:0] beyond_mask;
    logic [4:0] clr;
    logic [2:0] arrive_floor;
    logic       req_here;
    logic       req_above;
    logic       req_below;
    logic       arrive_hit;
    logic       arrive_beyond;
    logic       move_done;
    logic       door_done;

    // Request view and floor-relative masks; arrive_* describe the floor the
    // car reaches when the current travel step completes.
    always_comb begin
        req          = pending | buttons;
        above_mask   = '0;
        below_mask   = '0;
        here_mask    = '0;
        arrive_mask  = '0;
        beyond_mask  = '0;
        arrive_floor = (state == DOWN) ? current_floor - 3'd1 : current_floor + 3'd1;
        for (int i = 0; i < 5; i++) begin
            above_mask[i]  = (i > int'(current_floor));
            below_mask[i]  = (i < int'(current_floor));
            here_mask[i]   = (i == int'(current_floor));
            arrive_mask[i] = (i == int'(arrive_floor));
            beyond_mask[i] = (state == DOWN) ? (i < int'(arrive_floor))
                                             : (i > int'(arrive_floor));
        end
        req_here      = |(req & here_mask);
        req_above     = |(req & above_mask);
        req_below     = |(req & below_mask);
        arrive_hit    = |(req & arrive_mask);
        arrive_beyond = |(req & beyond_mask);
        move_done     = (move_cnt == MOVE_LAST);
        door_done     = (door_cnt == DOOR_LAST);

        clr = '0;
        case (state)
            IDLE:     if (req_here) clr = here_mask;
            UP, DOWN: if (move_done) clr = arrive_mask;
            DOOR:     clr = here_mask;
            default:  clr = '0;
        endcase
    end

    // Car FSM; a press of the floor being served is swallowed by clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            current_floor <= 3'd0;
            pending       <= '0;
            door_open     <= 1'b0;
            move_cnt      <= '0;
            door_cnt      <= '0;
            dir_up        <= 1'b1;
        end else begin
            pending <= req & ~clr;
            case (state)
                IDLE: begin
                    if (req_here) begin
                        state     <= DOOR;
                        door_open <= 1'b1;
                        door_cnt  <= '0;
                    end else if (req_above) begin
                        state    <= UP;
                        dir_up   <= 1'b1;
                        move_cnt <= '0;
                    end else if (req_below) begin
                        state    <= DOWN;
                        dir_up   <= 1'b0;
                        move_cnt <= '0;
                    end
                end
                UP, DOWN: begin
                    if (move_done) begin
                        current_floor <= arrive_floor;
                        move_cnt      <= '0;
                        if (arrive_hit) begin
                            state     <= DOOR;
                            door_open <= 1'b1;
                            door_cnt  <= '0;
                        end else if (!arrive_beyond) begin
                            state <= IDLE;
                        end
                    end else begin
                        move_cnt <= move_cnt + 1'b1;
                    end
                end
                DOOR: begin
                    if (door_done) begin
                        door_open <= 1'b0;
                        door_cnt  <= '0;
                        if (dir_up ? req_above : req_below) begin
                            state    <= dir_up ? UP : DOWN;
                            move_cnt <= '0;
                        end else if (dir_up ? req_below : req_above) begin
                            state    <= dir_up ? DOWN : UP;
                            dir_up   <= !dir_up;
                            move_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        door_cnt <= door_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator.sv
// Scoreboard bench for the elevator: each stimulus pushes its expected
// floor/door/pending trace, and a negedge monitor pops and compares it.
module tb_elevator;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] buttons;
    logic [2:0] current_floor;
    logic       door_open;
    logic [4:0] pending;

    typedef struct {
        int    cyc;
        string tag;
        int    floor;
        int    door;
        int    pend;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   edges = 0;
    int   compared = 0;
    int   mismatched = 0;

    elevator #(.MOVE_CYCLES(4), .DOOR_CYCLES(3)) dut (
        .clk(clk),
        .reset(reset),
        .buttons(buttons),
        .current_floor(current_floor),
        .door_open(door_open),
        .pending(pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic expectAt(input int cyc, input string tag, input int fl, input int dr, input int pd);
        exp_t e;
        e.cyc   = cyc;
        e.tag   = tag;
        e.floor = fl;
        e.door  = dr;
        e.pend  = pd;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [4:0] mask, output int k);
        buttons = mask;
        k = edges + 1;
    endtask

    task automatic releaseButtons(input int hold);
        repeat (hold) @(negedge clk);
        buttons = '0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb.size() > 0 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() > 0) begin
            checkOutput("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Values sampled after edge N are compared against entries scheduled for N.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= edges) begin
            mon_e = sb.pop_front();
            checkOutput({mon_e.tag, ".floor"}, int'(current_floor), mon_e.floor);
            checkOutput({mon_e.tag, ".door"}, int'(door_open), mon_e.door);
            checkOutput({mon_e.tag, ".pend"}, int'(pending), mon_e.pend);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int k2;
        reset   = 1'b1;
        buttons = 5'b11111;
        repeat (3) @(negedge clk);
        checkOutput("rst.floor", int'(current_floor), 0);
        checkOutput("rst.door", int'(door_open), 0);
        checkOutput("rst.pend", int'(pending), 0);
        buttons = '0;
        reset   = 1'b0;
        for (int i = 1; i <= 10; i++) expectAt(edges + i, "idle", 0, 0, 0);
        drain(20);

        $display("[TB] single request 0 -> 2");
        applyStimulus(5'b00100, k);
        expectAt(k,      "go2.start", 0, 0, 4);
        expectAt(k + 3,  "go2.hold0", 0, 0, 4);
        expectAt(k + 4,  "go2.f1",    1, 0, 4);
        expectAt(k + 7,  "go2.hold1", 1, 0, 4);
        expectAt(k + 8,  "go2.arrive", 2, 1, 0);
        expectAt(k + 10, "go2.dwell", 2, 1, 0);
        expectAt(k + 11, "go2.close", 2, 0, 0);
        releaseButtons(1);
        drain(40);

        $display("[TB] held press at current floor 2");
        applyStimulus(5'b00100, k);
        expectAt(k,     "here.open",  2, 1, 0);
        expectAt(k + 1, "here.abs1",  2, 1, 0);
        expectAt(k + 2, "here.abs2",  2, 1, 0);
        expectAt(k + 3, "here.close", 2, 0, 0);
        expectAt(k + 6, "here.idle",  2, 0, 0);
        releaseButtons(3);
        drain(20);

        $display("[TB] return to floor 0");
        applyStimulus(5'b00001, k);
        expectAt(k,      "ret0.start",  2, 0, 1);
        expectAt(k + 4,  "ret0.f1",     1, 0, 1);
        expectAt(k + 8,  "ret0.arrive", 0, 1, 0);
        expectAt(k + 11, "ret0.close",  0, 0, 0);
        releaseButtons(1);
        drain(30);

        $display("[TB] two requests 1 and 4");
        applyStimulus(5'b10010, k);
        expectAt(k,      "two.start",  0, 0, 18);
        expectAt(k + 4,  "two.stop1",  1, 1, 16);
        expectAt(k + 6,  "two.dwell1", 1, 1, 16);
        expectAt(k + 7,  "two.leave1", 1, 0, 16);
        expectAt(k + 11, "two.f2",     2, 0, 16);
        expectAt(k + 15, "two.f3",     3, 0, 16);
        expectAt(k + 19, "two.stop4",  4, 1, 0);
        expectAt(k + 21, "two.dwell4", 4, 1, 0);
        expectAt(k + 22, "two.close4", 4, 0, 0);
        expectAt(k + 30, "two.idle4",  4, 0, 0);
        releaseButtons(1);
        drain(50);

        applyStimulus(5'b00010, k);
        expectAt(k,      "prep.start",  4, 0, 2);
        expectAt(k + 4,  "prep.f3",     3, 0, 2);
        expectAt(k + 12, "prep.arrive", 1, 1, 0);
        expectAt(k + 15, "prep.close",  1, 0, 0);
        releaseButtons(1);
        drain(30);

        $display("[TB] request behind a car moving up");
        applyStimulus(5'b10000, k);
        expectAt(k,      "rev.start",  1, 0, 16);
        expectAt(k + 4,  "rev.f2",     2, 0, 16);
        expectAt(k + 6,  "rev.latch0", 2, 0, 17);
        expectAt(k + 8,  "rev.f3",     3, 0, 17);
        expectAt(k + 12, "rev.stop4",  4, 1, 1);
        expectAt(k + 15, "rev.leave4", 4, 0, 1);
        expectAt(k + 19, "rev.f3dn",   3, 0, 1);
        expectAt(k + 31, "rev.stop0",  0, 1, 0);
        expectAt(k + 34, "rev.close0", 0, 0, 0);
        expectAt(k + 40, "rev.idle0",  0, 0, 0);
        releaseButtons(1);
        repeat (4) @(negedge clk);
        applyStimulus(5'b00001, k2);
        releaseButtons(1);
        drain(60);

        $display("[TB] reset during travel");
        applyStimulus(5'b10000, k);
        expectAt(k,     "abort.start", 0, 0, 16);
        expectAt(k + 4, "abort.f1",    1, 0, 16);
        expectAt(k + 8, "abort.f2",    2, 0, 16);
        expectAt(k + 9, "abort.latch", 2, 0, 17);
        releaseButtons(1);
        repeat (8) @(negedge clk);
        applyStimulus(5'b00001, k2);
        releaseButtons(1);
        @(negedge clk);
        reset   = 1'b1;
        buttons = 5'b11111;
        #1;
        checkOutput("abort.floor", int'(current_floor), 0);
        checkOutput("abort.door", int'(door_open), 0);
        checkOutput("abort.pend", int'(pending), 0);
        repeat (2) @(negedge clk);
        checkOutput("abort.hold_pend", int'(pending), 0);
        checkOutput("abort.hold_floor", int'(current_floor), 0);
        buttons = '0;
        reset   = 1'b0;
        for (int i = 1; i <= 10; i++) expectAt(edges + i, "abort.idle", 0, 0, 0);
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
